cpu_stage_sequencer: RTL and testbench
======================================

Name: cpu_stage_sequencer

Overview:
- Multi-cycle control FSM for the Rv32H core.
- Steps one instruction at a time through fetch, decode, execute (ALU), memory and writeback, asserting each stage's execute enable and waiting for its ready.
- Owns the architectural PC, updating it from the writeback stage's branch and next-PC outputs.
- Counts retired instructions and traps hung stages or misaligned branch targets into a sticky fault state.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
STALL_TIMEOUT, 8'd255, max cycles a stage may hold off ready before fault (legal range 1..255).

Ports:
i_clock  in  1  core clock, rising edge.
i_reset  in  1  asynchronous, active-low reset.
i_run  in  1  level; allows a new instruction to start.
o_fetch_execute  out  1  fetch enable.
i_fetch_ready  in  1  fetch done.
o_decode_execute  out  1  decode enable.
i_decode_ready  in  1  decode done.
o_alu_execute  out  1  ALU stage enable.
i_alu_ready  in  1  ALU done.
o_memory_execute  out  1  memory stage enable.
i_memory_ready  in  1  memory done.
o_writeback_execute  out  1  writeback enable.
i_writeback_ready  in  1  writeback done.
i_wb_branch  in  1  writeback reports taken branch; valid while i_writeback_ready=1.
i_wb_pc_next  in  32  branch target; valid while i_writeback_ready=1.
o_pc  out  32  current instruction PC.
o_retired  out  32  retired-instruction count.
o_fault  out  1  sticky fault flag.
o_state  out  3  encoded FSM state (debug).

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, ALU=3, MEMORY=4, WRITEBACK=5, FAULT=6.
- All outputs are registered.
- Reset (i_reset=0, asynchronous, no clock required):
  - state=IDLE, o_pc=RESET_PC, o_retired=0, o_fault=0.
  - All execute outputs 0; stall counter 0.
- IDLE: if i_run=1 at an edge, go to FETCH; otherwise hold.
- Stage states (FETCH..WRITEBACK):
  - The matching o_*_execute is 1 for every cycle in the state; the others are 0. Execute outputs are one-hot or all-zero at all times.
  - On an edge where the matching ready=1: advance to the next stage and clear the stall counter. The current execute drops and the next stage's execute rises on that same edge.
  - Ready inputs of non-matching stages are ignored.
- Latency: stages register ready one edge after seeing execute, so each stage costs at least 2 cycles. Minimum is 10 cycles per instruction, FETCH entry to the next FETCH entry.
- Stages must tolerate execute being sampled high on consecutive edges.
- Stall counter (8-bit):
  - Increments each cycle in a stage state while the matching ready=0.
  - If it reaches STALL_TIMEOUT with ready still 0: go to FAULT.
- WRITEBACK completion, on the edge where i_writeback_ready=1:
  - i_wb_branch=1 and i_wb_pc_next[1:0]!=0: go to FAULT. o_pc and o_retired are unchanged.
  - i_wb_branch=1, aligned target: o_pc <= i_wb_pc_next.
  - i_wb_branch=0: o_pc <= o_pc+4, wrapping modulo 2^32 (0xFFFFFFFC -> 0).
  - When not faulting: o_retired <= o_retired+1, wrapping modulo 2^32.
  - Next state is FETCH if i_run=1, else IDLE.
- i_run=0 mid-instruction: the current instruction completes through WRITEBACK, then the FSM enters IDLE. i_run is only checked in IDLE and at writeback completion.
- FAULT: all execute outputs 0, o_fault=1. Only reset exits FAULT; i_run is ignored.
- o_state always reflects the current state register.

Test Plan:
- Reset with i_run=1 held → o_pc=0, o_retired=0, o_state=0, all execute 0. After release, o_fetch_execute=1 on the first edge.
- Stage stubs (ready registered 1 cycle after execute), i_run=1 for 1 instruction then 0, no branch → each execute high 2 cycles in order; o_pc 0→4, o_retired=1, state returns to IDLE 10 cycles after FETCH entry.
- Writeback with i_wb_branch=1, i_wb_pc_next=0x00000100 → o_pc=0x100, o_retired increments. Next instruction with no branch → o_pc=0x104.
- Writeback with i_wb_branch=1, i_wb_pc_next=0x00000102 → o_state=6, o_fault=1, o_pc and o_retired unchanged. Fault persists with i_run=1 until reset.
- STALL_TIMEOUT=4, i_memory_ready held 0 → FAULT entered 4 cycles after MEMORY entry, o_memory_execute=0 thereafter. Separately, a ready arriving on cycle 3 → no fault.
- Assert i_reset=0 mid-DECODE between clock edges → o_decode_execute=0, o_state=0, o_pc=RESET_PC immediately, without a clock edge.

Source files
------------

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle stage sequencer for the Rv32H core: steps one instruction through
// fetch/decode/ALU/memory/writeback, owns the PC, counts retirements, traps faults.
module cpu_stage_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [7:0]  STALL_TIMEOUT = 8'd255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_run,
  output logic        o_fetch_execute,
  input  logic        i_fetch_ready,
  output logic        o_decode_execute,
  input  logic        i_decode_ready,
  output logic        o_alu_execute,
  input  logic        i_alu_ready,
  output logic        o_memory_execute,
  input  logic        i_memory_ready,
  output logic        o_writeback_execute,
  input  logic        i_writeback_ready,
  input  logic        i_wb_branch,
  input  logic [31:0] i_wb_pc_next,
  output logic [31:0] o_pc,
  output logic [31:0] o_retired,
  output logic        o_fault,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_ALU       = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  state_t      state, next_state;
  logic [7:0]  stall_cnt, stall_next;
  logic [31:0] pc_q, pc_next;
  logic [31:0] retired_q;
  logic        retire;
  logic        stage_ready;
  logic [4:0]  exec_q, exec_d;
  logic        fault_q, fault_d;

  // State register; execute/fault outputs are registered from the next state
  // so each enable changes on the same edge as the state it belongs to.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      stall_cnt <= '0;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      exec_q    <= '0;
      fault_q   <= 1'b0;
    end else begin
      state     <= next_state;
      stall_cnt <= stall_next;
      exec_q    <= exec_d;
      fault_q   <= fault_d;
      if (retire) begin
        pc_q      <= pc_next;
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  always_comb begin
    next_state  = state;
    stall_next  = '0;
    retire      = 1'b0;
    pc_next     = pc_q + 32'd4;
    stage_ready = 1'b0;
    case (state)
      ST_FETCH:     stage_ready = i_fetch_ready;
      ST_DECODE:    stage_ready = i_decode_ready;
      ST_ALU:       stage_ready = i_alu_ready;
      ST_MEMORY:    stage_ready = i_memory_ready;
      ST_WRITEBACK: stage_ready = i_writeback_ready;
      default:      stage_ready = 1'b0;
    endcase

    case (state)
      ST_IDLE: if (i_run) next_state = ST_FETCH;
      ST_FETCH, ST_DECODE, ST_ALU, ST_MEMORY, ST_WRITEBACK: begin
        if (stage_ready) begin
          case (state)
            ST_FETCH:  next_state = ST_DECODE;
            ST_DECODE: next_state = ST_ALU;
            ST_ALU:    next_state = ST_MEMORY;
            ST_MEMORY: next_state = ST_WRITEBACK;
            default: begin
              if (i_wb_branch && (i_wb_pc_next[1:0] != 2'b00)) begin
                next_state = ST_FAULT;
              end else begin
                retire     = 1'b1;
                if (i_wb_branch) pc_next = i_wb_pc_next;
                next_state = i_run ? ST_FETCH : ST_IDLE;
              end
            end
          endcase
        end else if (stall_cnt == (STALL_TIMEOUT - 8'd1)) begin
          next_state = ST_FAULT;
        end else begin
          stall_next = stall_cnt + 8'd1;
        end
      end
      ST_FAULT: next_state = ST_FAULT;
      default:  next_state = ST_FAULT;
    endcase
  end

  always_comb begin
    exec_d = '0;
    case (next_state)
      ST_FETCH:     exec_d = 5'b00001;
      ST_DECODE:    exec_d = 5'b00010;
      ST_ALU:       exec_d = 5'b00100;
      ST_MEMORY:    exec_d = 5'b01000;
      ST_WRITEBACK: exec_d = 5'b10000;
      default:      exec_d = '0;
    endcase
    fault_d = (next_state == ST_FAULT);
  end

  assign o_fetch_execute     = exec_q[0];
  assign o_decode_execute    = exec_q[1];
  assign o_alu_execute       = exec_q[2];
  assign o_memory_execute    = exec_q[3];
  assign o_writeback_execute = exec_q[4];
  assign o_pc                = pc_q;
  assign o_retired           = retired_q;
  assign o_fault             = fault_q;
  assign o_state             = state;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Directed bench for cpu_stage_sequencer: registered-ready stage stubs, branch,
// misaligned-branch fault, stall timeout (STALL_TIMEOUT=4) and async reset.
module tb_cpu_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        fetch_ex, decode_ex, alu_ex, mem_ex, wb_ex;
  logic        wb_branch;
  logic [31:0] wb_pc_next;
  logic [31:0] pc, retired;
  logic        fault;
  logic [2:0]  state;
  logic [4:0]  stub_ready;
  logic        hold_mem;
  logic        mem_manual;
  logic        mem_ready;
  logic [4:0]  exec_vec;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  assign exec_vec  = {wb_ex, mem_ex, alu_ex, decode_ex, fetch_ex};
  assign mem_ready = stub_ready[3] | mem_manual;

  // Stage stubs: ready is the execute enable registered one edge later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) stub_ready <= '0;
    else        stub_ready <= exec_vec & {1'b1, ~hold_mem, 3'b111};
  end

  cpu_stage_sequencer #(.STALL_TIMEOUT(8'd4)) dut (
    .i_clock             (clk),
    .i_reset             (rst_n),
    .i_run               (run),
    .o_fetch_execute     (fetch_ex),
    .i_fetch_ready       (stub_ready[0]),
    .o_decode_execute    (decode_ex),
    .i_decode_ready      (stub_ready[1]),
    .o_alu_execute       (alu_ex),
    .i_alu_ready         (stub_ready[2]),
    .o_memory_execute    (mem_ex),
    .i_memory_ready      (mem_ready),
    .o_writeback_execute (wb_ex),
    .i_writeback_ready   (stub_ready[4]),
    .i_wb_branch         (wb_branch),
    .i_wb_pc_next        (wb_pc_next),
    .o_pc                (pc),
    .o_retired           (retired),
    .o_fault             (fault),
    .o_state             (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_neg(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; wb_branch = 1'b0; wb_pc_next = '0;
    hold_mem = 1'b0; mem_manual = 1'b0;

    // Reset with run held high
    #2;
    check("rst_pc", pc, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_exec", {27'd0, exec_vec}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);

    @(negedge clk);            // t=10
    rst_n = 1'b1;
    @(negedge clk);            // t=20, FETCH entered at 15
    check("first_fetch", {31'd0, fetch_ex}, 32'd1);
    run = 1'b0;

    // One instruction, no branch: each stage two cycles, in order
    for (int s = 1; s <= 5; s++) begin
      for (int c = 0; c < 2; c++) begin
        check($sformatf("seq_state_s%0d_c%0d", s, c), {29'd0, state}, s);
        check($sformatf("seq_exec_s%0d_c%0d", s, c), {27'd0, exec_vec}, 32'd1 << (s - 1));
        @(negedge clk);
      end
    end
    // t=120
    check("idle_state", {29'd0, state}, 32'd0);
    check("idle_pc", pc, 32'h4);
    check("idle_retired", retired, 32'd1);
    check("idle_exec", {27'd0, exec_vec}, 32'd0);

    // Aligned taken branch then a sequential instruction
    run = 1'b1; wb_branch = 1'b1; wb_pc_next = 32'h0000_0100;
    wait_neg(1);               // t=130
    check("br_fetch", {29'd0, state}, 32'd1);
    wait_neg(10);              // t=230
    check("br_state", {29'd0, state}, 32'd1);
    check("br_pc", pc, 32'h100);
    check("br_retired", retired, 32'd2);
    wb_branch = 1'b0; run = 1'b0;
    wait_neg(10);              // t=330
    check("seq_after_br_state", {29'd0, state}, 32'd0);
    check("seq_after_br_pc", pc, 32'h104);
    check("seq_after_br_retired", retired, 32'd3);

    // Memory never ready: fault 4 cycles after MEMORY entry (entry at 395)
    run = 1'b1; hold_mem = 1'b1;
    wait_neg(1);               // t=340
    run = 1'b0;
    wait_neg(9);               // t=430
    check("stall_pre_state", {29'd0, state}, 32'd4);
    check("stall_pre_memex", {31'd0, mem_ex}, 32'd1);
    wait_neg(1);               // t=440
    check("stall_fault_state", {29'd0, state}, 32'd6);
    check("stall_fault_flag", {31'd0, fault}, 32'd1);
    check("stall_fault_exec", {27'd0, exec_vec}, 32'd0);
    run = 1'b1;
    wait_neg(2);               // t=460
    check("stall_fault_sticky", {29'd0, state}, 32'd6);

    // Reset out of FAULT
    wait_neg(1);               // t=470
    rst_n = 1'b0;
    #1;
    check("rst2_state", {29'd0, state}, 32'd0);
    check("rst2_fault", {31'd0, fault}, 32'd0);
    check("rst2_pc", pc, 32'h0);
    check("rst2_retired", retired, 32'd0);

    // Memory ready arriving on the 4th edge after entry: no fault (entry at 545)
    @(negedge clk);            // t=480
    rst_n = 1'b1; run = 1'b1;
    wait_neg(10);              // t=580
    check("late_mem_state", {29'd0, state}, 32'd4);
    mem_manual = 1'b1; run = 1'b0;
    wait_neg(1);               // t=590
    check("late_mem_adv", {29'd0, state}, 32'd5);
    check("late_mem_nofault", {31'd0, fault}, 32'd0);
    mem_manual = 1'b0; hold_mem = 1'b0;
    wait_neg(2);               // t=610
    check("late_mem_idle", {29'd0, state}, 32'd0);
    check("late_mem_pc", pc, 32'h4);
    check("late_mem_retired", retired, 32'd1);

    // Misaligned branch target: fault, pc/retired unchanged
    run = 1'b1; wb_branch = 1'b1; wb_pc_next = 32'h0000_0102;
    wait_neg(11);              // t=720
    check("mis_state", {29'd0, state}, 32'd6);
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_pc", pc, 32'h4);
    check("mis_retired", retired, 32'd1);
    check("mis_exec", {27'd0, exec_vec}, 32'd0);
    wait_neg(3);               // t=750
    check("mis_sticky", {29'd0, state}, 32'd6);

    // Async reset mid-DECODE, between clock edges
    rst_n = 1'b0; wb_branch = 1'b0;
    @(negedge clk);            // t=760
    rst_n = 1'b1;
    wait_neg(3);               // t=790, DECODE entered at 785
    check("mid_dec_state", {29'd0, state}, 32'd2);
    check("mid_dec_ex", {31'd0, decode_ex}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_dec_ex", {31'd0, decode_ex}, 32'd0);
    check("async_state", {29'd0, state}, 32'd0);
    check("async_pc", pc, 32'h0);
    check("async_exec", {27'd0, exec_vec}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
